// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrAddr,
    StHdrLen,
    StData,
    StCsum,
    StWrite
  } state_e;

  localparam logic [1:0] ERR_CSUM    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] DefaultSofByte = 8'hA5;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: MaxLen x 8 register array, one write port, combinational read.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int unsigned MaxLen = 16,
  localparam int unsigned IdxW = idx_width(MaxLen)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [IdxW-1:0] raddr_i,
  output logic [7:0]      rdata_o
);

  logic [7:0] mem_q [MaxLen];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Parses SOF/ADDR/LEN/payload/XOR-checksum frames and commits payload to a register port.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned AddrW      = 8,
  parameter logic [7:0]  SofByte    = DefaultSofByte,
  parameter int unsigned MaxLen     = 16,
  parameter int unsigned TimeoutCyc = 21700
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             wr_en_o,
  output logic [AddrW-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  input  logic             wr_ready_i,
  output logic             frame_ok_o,
  output logic             frame_err_o,
  output logic [1:0]       err_code_o,
  output logic             busy_o
);

  localparam int unsigned IdxW    = idx_width(MaxLen);
  localparam logic [7:0]  MaxLenB = 8'(MaxLen);

  state_e           state_q, state_d;
  logic [AddrW-1:0] base_q, base_d, wr_addr_q, wr_addr_d;
  logic [7:0]       len_q, len_d, idx_q, idx_d, csum_q, csum_d, wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d, frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic             ovr_pend_q, ovr_pend_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [7:0]       idx_inc, rd_data;
  logic [IdxW-1:0]  rd_idx;
  logic             buf_we;

  assign idx_inc = idx_q + 8'd1;
  // Look ahead to the next entry so the accepted write is replaced on the following cycle.
  assign rd_idx  = (state_q == StWrite) ? idx_inc[IdxW-1:0] : '0;
  assign buf_we  = (state_q == StData) && rx_valid_i;

  uart_frame_buf #(
    .MaxLen (MaxLen)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (idx_q[IdxW-1:0]),
    .wdata_i (rx_data_i),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned CntW = idx_width(TimeoutCyc);
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCyc;
`endif

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    ovr_pend_d  = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    if (ovr_pend_q) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_OVERRUN;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_valid_i && (rx_data_i == SofByte)) state_d = StHdrAddr;
      end
      StHdrAddr: begin
        if (rx_valid_i) begin
          base_d  = AddrW'(rx_data_i);
          csum_d  = rx_data_i;
          state_d = StHdrLen;
        end
      end
      StHdrLen: begin
        if (rx_valid_i) begin
          len_d  = rx_data_i;
          csum_d = csum_q ^ rx_data_i;
          if ((rx_data_i == 8'd0) || (rx_data_i > MaxLenB)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = StIdle;
          end else begin
            idx_d   = 8'd0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (rx_valid_i) begin
          csum_d = csum_q ^ rx_data_i;
          idx_d  = idx_inc;
          if (idx_inc == len_q) state_d = StCsum;
        end
      end
      StCsum: begin
        if (rx_valid_i) begin
          if (rx_data_i == csum_q) begin
            idx_d     = 8'd0;
            wr_en_d   = 1'b1;
            wr_addr_d = base_q;
            wr_data_d = rd_data;
            state_d   = StWrite;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = StIdle;
          end
        end
      end
      StWrite: begin
        if (wr_en_q && wr_ready_i) begin
          if (idx_inc == len_q) begin
            wr_en_d    = 1'b0;
            frame_ok_d = 1'b1;
            state_d    = StIdle;
          end else begin
            idx_d     = idx_inc;
            wr_addr_d = base_q + AddrW'(idx_inc);
            wr_data_d = rd_data;
          end
        end
        // A byte arriving while draining is dropped; frame_ok wins a same-cycle clash.
        if (rx_valid_i) begin
          if (frame_ok_d) begin
            ovr_pend_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_OVERRUN;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef UART_FRAME_TIMEOUT_EN
    if (rx_valid_i) begin
      cnt_d = '0;
    end else if (state_q inside {StHdrAddr, StHdrLen, StData, StCsum}) begin
      if (cnt_q == CntW'(TimeoutCyc - 1)) begin
        cnt_d       = '0;
        frame_err_d = 1'b1;
        err_code_d  = ERR_TIMEOUT;
        state_d     = StIdle;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      ovr_pend_q  <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      ovr_pend_q  <= ovr_pend_d;
`ifdef UART_FRAME_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign err_code_o  = err_code_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed table-driven bench for uart_rx_frame_ctrl plus hand-written multi-cycle sequences.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       wr_ready = 1'b1;
  logic       wr_en, frame_ok, frame_err, busy;
  logic [7:0] wr_addr, wr_data;
  logic [1:0] err_code;

  uart_rx_frame_ctrl #(
    .AddrW      (8),
    .SofByte    (8'hA5),
    .MaxLen     (16),
    .TimeoutCyc (100)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .wr_ready_i  (wr_ready),
    .frame_ok_o  (frame_ok),
    .frame_err_o (frame_err),
    .err_code_o  (err_code),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs accepted writes and pulses, checks that stalled writes hold steady.
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int         wc[$];
  int ok_cnt = 0, ok_cyc = 0, err_cnt = 0, err_cyc = 0, last_rx_cyc = 0;
  int hold_bad = 0, stalls = 0;
  logic [1:0] err_cd = 2'd0;
  logic       p_stall = 1'b0;
  logic [7:0] p_addr = 8'h00, p_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall <= 1'b0;
    end else begin
      if (p_stall && !(wr_en && wr_addr == p_addr && wr_data == p_data)) hold_bad <= hold_bad + 1;
      p_stall <= wr_en && !wr_ready;
      if (wr_en && !wr_ready) stalls <= stalls + 1;
      p_addr <= wr_addr;
      p_data <= wr_data;
      if (wr_en && wr_ready) begin
        wa.push_back(wr_addr);
        wd.push_back(wr_data);
        wc.push_back(cyc);
      end
      if (frame_ok) begin
        ok_cnt <= ok_cnt + 1;
        ok_cyc <= cyc;
      end
      if (frame_err) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
        err_cd  <= err_code;
      end
      if (rx_valid) last_rx_cyc <= cyc;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [19:0][7:0] b;
    int               n;
    logic [15:0][7:0] ea;
    logic [15:0][7:0] ed;
    int               nwr;
    logic             eok;
    logic             eerr;
    logic [1:0]       ecode;
  } vec_t;

  localparam int NV = 7;
  vec_t v [NV];

  task automatic push(input int k, input logic [7:0] x);
    v[k].b[v[k].n] = x;
    v[k].n++;
  endtask

  task automatic expw(input int k, input logic [7:0] a, input logic [7:0] d);
    v[k].ea[v[k].nwr] = a;
    v[k].ed[v[k].nwr] = d;
    v[k].nwr++;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while (busy && t < lim) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= lim) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, lim);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  int s_w, s_ok, s_err, s_stall;
  task automatic snap();
    s_w = wa.size();
    s_ok = ok_cnt;
    s_err = err_cnt;
    s_stall = stalls;
  endtask

  task automatic chk_writes(input string nm, input int k);
    chk({nm, "_nwr"}, wa.size() - s_w, v[k].nwr);
    for (int i = 0; i < v[k].nwr && i < wa.size() - s_w; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), wa[s_w + i], v[k].ea[i]);
      chk($sformatf("%s_data%0d", nm, i), wd[s_w + i], v[k].ed[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NV; k++) v[k] = '0;
    // v0: good 3-byte frame
    push(0, 8'hA5); push(0, 8'h10); push(0, 8'h03); push(0, 8'h11); push(0, 8'h22);
    push(0, 8'h33); push(0, 8'h13);
    expw(0, 8'h10, 8'h11); expw(0, 8'h11, 8'h22); expw(0, 8'h12, 8'h33);
    v[0].eok = 1'b1;
    // v1: bad checksum
    push(1, 8'hA5); push(1, 8'h10); push(1, 8'h03); push(1, 8'h11); push(1, 8'h22);
    push(1, 8'h33); push(1, 8'h14);
    v[1].eerr = 1'b1; v[1].ecode = 2'd0;
    // v2: LEN=0, trailing byte dropped in idle
    push(2, 8'hA5); push(2, 8'h00); push(2, 8'h00); push(2, 8'h00);
    v[2].eerr = 1'b1; v[2].ecode = 2'd1;
    // v3: LEN=17 > MaxLen
    push(3, 8'hA5); push(3, 8'h00); push(3, 8'h11);
    v[3].eerr = 1'b1; v[3].ecode = 2'd1;
    // v4: non-SOF byte in idle
    push(4, 8'h5A);
    // v5: LEN=MaxLen with address wrap; csum F8^10^(xor 0..F)=E8
    push(5, 8'hA5); push(5, 8'hF8); push(5, 8'h10);
    for (int i = 0; i < 16; i++) begin
      push(5, 8'(i));
      expw(5, 8'hF8 + 8'(i), 8'(i));
    end
    push(5, 8'hE8);
    v[5].eok = 1'b1;
    // v6: LEN=1; csum 30^01^44=75
    push(6, 8'hA5); push(6, 8'h30); push(6, 8'h01); push(6, 8'h44); push(6, 8'h75);
    expw(6, 8'h30, 8'h44);
    v[6].eok = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_init", {wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy}, 0);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      wr_ready = 1'b1;
      snap();
      for (int i = 0; i < v[k].n; i++) send(v[k].b[i]);
      wait_idle(40);
      chk_writes($sformatf("v%0d", k), k);
      chk($sformatf("v%0d_ok", k), ok_cnt - s_ok, int'(v[k].eok));
      chk($sformatf("v%0d_err", k), err_cnt - s_err, int'(v[k].eerr));
      if (v[k].eerr) chk($sformatf("v%0d_code", k), err_cd, v[k].ecode);
      if (v[k].nwr > 0 && wa.size() - s_w == v[k].nwr) begin
        chk($sformatf("v%0d_lat", k), wc[s_w] - last_rx_cyc, 1);
        chk($sformatf("v%0d_b2b", k), wc[s_w + v[k].nwr - 1] - wc[s_w], v[k].nwr - 1);
        chk($sformatf("v%0d_okcyc", k), ok_cyc - wc[s_w + v[k].nwr - 1], 1);
      end
      chk($sformatf("v%0d_busy", k), busy, 0);
    end
    chk("code_hold", err_code, 2'd1);

    // Address wrap with stalling sink; csum FE^03^01^02^03=FD
    wr_ready = 1'b0;
    snap();
    v[0] = '0;
    push(0, 8'hA5); push(0, 8'hFE); push(0, 8'h03); push(0, 8'h01); push(0, 8'h02);
    push(0, 8'h03); push(0, 8'hFD);
    expw(0, 8'hFE, 8'h01); expw(0, 8'hFF, 8'h02); expw(0, 8'h00, 8'h03);
    for (int i = 0; i < v[0].n; i++) send(v[0].b[i]);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      wr_ready = ~wr_ready;
    end
    wr_ready = 1'b1;
    wait_idle(40);
    chk_writes("wrap", 0);
    chk("wrap_stalled", int'(stalls - s_stall > 0), 1);
    chk("wrap_ok", ok_cnt - s_ok, 1);

    // Overrun while the sink is blocked
    wr_ready = 1'b0;
    snap();
    v[0] = '0;
    push(0, 8'hA5); push(0, 8'h10); push(0, 8'h03); push(0, 8'h11); push(0, 8'h22);
    push(0, 8'h33); push(0, 8'h13);
    expw(0, 8'h10, 8'h11); expw(0, 8'h11, 8'h22); expw(0, 8'h12, 8'h33);
    for (int i = 0; i < v[0].n; i++) send(v[0].b[i]);
    repeat (2) @(posedge clk);
    send(8'h77);
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_err", err_cnt - s_err, 1);
    chk("ovr_code", err_cd, 2'd3);
    chk("ovr_nowr", wa.size() - s_w, 0);
    chk("ovr_held", {wr_en, wr_addr, wr_data}, {1'b1, 8'h10, 8'h11});
    wr_ready = 1'b1;
    wait_idle(40);
    chk_writes("ovr", 0);
    chk("ovr_ok", ok_cnt - s_ok, 1);

    // frame_ok and an overrun in the same cycle: overrun deferred one cycle
    snap();
    send(8'hA5); send(8'h30); send(8'h01); send(8'h44);
    @(posedge clk); #1; rx_valid = 1'b1; rx_data = 8'h75;
    @(posedge clk); #1; rx_data = 8'hEE;
    @(posedge clk); #1; rx_valid = 1'b0; rx_data = 8'h00;
    wait_idle(40);
    chk("sim_nwr", wa.size() - s_w, 1);
    chk("sim_ok", ok_cnt - s_ok, 1);
    chk("sim_err", err_cnt - s_err, 1);
    chk("sim_code", err_cd, 2'd3);
    chk("sim_order", err_cyc - ok_cyc, 1);

    // Silence after SOF
    snap();
    send(8'hA5);
    repeat (150) @(posedge clk);
    #1;
`ifdef UART_FRAME_TIMEOUT_EN
    chk("tmo_err", err_cnt - s_err, 1);
    chk("tmo_code", err_cd, 2'd2);
    chk("tmo_cyc", err_cyc - last_rx_cyc, 101);
    chk("tmo_busy", busy, 0);
    send(8'hA5);
`else
    chk("notmo_err", err_cnt - s_err, 0);
    chk("notmo_busy", busy, 1);
`endif

    // Reset mid-DATA, then a clean frame
    send(8'h10); send(8'h03); send(8'h11);
    chk("data_busy", busy, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    snap();
    for (int i = 0; i < v[0].n; i++) send(v[0].b[i]);
    wait_idle(40);
    chk_writes("post_rst", 0);
    chk("post_rst_ok", ok_cnt - s_ok, 1);
    chk("post_rst_err", err_cnt - s_err, 0);
    chk("hold", hold_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
